// File: rtl/multicycle_mem_ctrl.sv
// Unified instruction/data memory for the multicycle core: valid/ready request,
// fixed-latency one-cycle response pulse, programmable wait states, fault flagging.
module multicycle_mem_ctrl #(
   parameter int MEM_WORDS   = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int IDX_W = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;

   logic              we_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;

   logic              rsp_valid_q;
   logic [31:0]       rsp_rdata_q;
   logic              rsp_err_q;

   logic [31:0]       mem [MEM_WORDS];

   logic              hs;
   logic              enter_resp;
   logic              acc_we;
   logic [31:0]       acc_addr;
   logic [31:0]       acc_wdata;
   logic [3:0]        acc_wstrb;
   logic              acc_err;
   logic [IDX_W-1:0]  acc_idx;

   // Misaligned or beyond the array; the full word index is compared so high
   // addresses never alias onto low words.
   function automatic logic addr_fault(input logic [31:0] a);
      logic [31:0] word;
      word = {2'b00, a[31:2]};
      return (a[1:0] != 2'b00) || (word >= 32'(MEM_WORDS));
   endfunction

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (hs) begin
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output / datapath-control logic
   always_comb begin
      req_ready  = reset_n && (state_q == S_IDLE);
      hs         = req_valid && req_ready;
      enter_resp = (state_d == S_RESP);
      // With zero wait states the access happens on the handshake edge itself,
      // before the request latches have been loaded.
      if (state_q == S_IDLE) begin
         acc_we    = req_we;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_wstrb = req_wstrb;
      end else begin
         acc_we    = we_q;
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
         acc_wstrb = wstrb_q;
      end
      acc_err = addr_fault(acc_addr);
      acc_idx = acc_addr[IDX_W+1:2];
   end

   always_ff @(posedge clock) begin
      if (hs) begin
         we_q    <= req_we;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         wstrb_q <= req_wstrb;
      end
   end

   always_ff @(posedge clock) begin
      if (enter_resp && acc_we && !acc_err) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_wstrb[b]) begin
               mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
         end
      end
   end

   // Response register; data and error hold between pulses
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else if (enter_resp) begin
         rsp_valid_q <= 1'b1;
         rsp_err_q   <= acc_err;
         rsp_rdata_q <= (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
      end else begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_multicycle_mem_ctrl.sv
// Scoreboarded directed bench for multicycle_mem_ctrl: a 2-wait-state instance
// for the main sequence and a 0-wait-state instance for the fast path.
module tb_multicycle_mem_ctrl;

   localparam int WA = 2;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_wstrb = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic        b_valid = 1'b0;
   logic        b_ready;
   logic        b_we = 1'b0;
   logic [31:0] b_addr = '0;
   logic [31:0] b_wdata = '0;
   logic [3:0]  b_wstrb = '0;
   logic        b_rsp_valid;
   logic [31:0] b_rsp_rdata;
   logic        b_rsp_err;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea;
   exp_t eb;

   multicycle_mem_ctrl #(.MEM_WORDS(1024), .WAIT_CYCLES(WA)) dut (
      .clock(clock), .reset_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   multicycle_mem_ctrl #(.MEM_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
      .clock(clock), .reset_n(rst_n),
      .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
      .req_addr(b_addr), .req_wdata(b_wdata), .req_wstrb(b_wstrb),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   always @(negedge clock) begin
      if (rsp_valid === 1'b1) begin
         if (qa.size() == 0) begin
            check("a_unexpected_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            ea = qa.pop_front();
            check("a_rdata", rsp_rdata, ea.rdata);
            check("a_err", 32'(rsp_err), 32'(ea.err));
            check("a_latency", 32'(cyc), 32'(ea.acc + WA));
         end
      end
   end

   always @(negedge clock) begin
      if (b_rsp_valid === 1'b1) begin
         if (qb.size() == 0) begin
            check("b_unexpected_rsp", 32'(b_rsp_valid), 32'd0);
         end else begin
            eb = qb.pop_front();
            check("b_rdata", b_rsp_rdata, eb.rdata);
            check("b_err", 32'(b_rsp_err), 32'(eb.err));
            check("b_latency", 32'(cyc), 32'(eb.acc));
         end
      end
   end

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] exp_rdata, input logic exp_err);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clock);
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = strb;
      req_valid = 1'b1;
      while (req_ready !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (req_ready !== 1'b1) begin
         check("accept_timeout", 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clock);
      #1;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.acc   = cyc;
      qa.push_back(e);
      // Scramble the bus after the handshake; the latched request must win.
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_wstrb = 4'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((qa.size() > 0 || qb.size() > 0) && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("drain_pending", 32'(qa.size() + qb.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      int   a1, a2;
      int   n;

      // Reset state
      #2;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_err", 32'(rsp_err), 32'd0);
      check("rst_b_ready", 32'(b_ready), 32'd0);
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      #1;
      check("ready_after_rst", 32'(req_ready), 32'd1);

      // Known word at 0x10, then a store aborted by reset mid-WAIT
      do_req(1'b1, 32'h10, 32'h0BADF00D, 4'hF, 32'd0, 1'b0);
      drain();
      @(negedge clock);
      req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF; req_wstrb = 4'hF;
      req_valid = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      @(negedge clock);
      rst_n = 1'b0;
      #1;
      check("midrst_ready", 32'(req_ready), 32'd0);
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clock);
      rst_n = 1'b1;
      #1;
      check("midrst_ready_after", 32'(req_ready), 32'd1);
      repeat (4) @(negedge clock);
      do_req(1'b0, 32'h10, 32'd0, 4'h0, 32'h0BADF00D, 1'b0);

      // Store/load
      do_req(1'b1, 32'h20, 32'h12345678, 4'hF, 32'd0, 1'b0);
      do_req(1'b0, 32'h20, 32'd0, 4'hF, 32'h12345678, 1'b0);

      // Byte strobes
      do_req(1'b1, 32'h8, 32'hAABBCCDD, 4'hF, 32'd0, 1'b0);
      do_req(1'b1, 32'h8, 32'h11223344, 4'b0101, 32'd0, 1'b0);
      do_req(1'b0, 32'h8, 32'd0, 4'h0, 32'hAA22CC44, 1'b0);

      // Faults, no aliasing, empty-strobe store, top word
      do_req(1'b1, 32'h0, 32'h55AA00FF, 4'hF, 32'd0, 1'b0);
      do_req(1'b0, 32'h22, 32'd0, 4'h0, 32'd0, 1'b1);
      do_req(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1);
      do_req(1'b0, 32'h0, 32'd0, 4'h0, 32'h55AA00FF, 1'b0);
      do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'd0, 1'b0);
      do_req(1'b0, 32'h20, 32'd0, 4'h0, 32'h12345678, 1'b0);
      do_req(1'b1, 32'hFFC, 32'hC0DE1234, 4'hF, 32'd0, 1'b0);
      do_req(1'b0, 32'hFFC, 32'd0, 4'h0, 32'hC0DE1234, 1'b0);
      do_req(1'b0, 32'hFFFFFFFC, 32'd0, 4'h0, 32'd0, 1'b1);
      drain();

      // req_valid held across two loads
      @(negedge clock);
      req_we = 1'b0; req_addr = 32'h20; req_wstrb = 4'h0; req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      @(posedge clock);
      #1;
      a1 = cyc;
      e.rdata = 32'h12345678; e.err = 1'b0; e.acc = cyc;
      qa.push_back(e);
      req_addr = 32'h8;
      for (int k = 0; k < WA + 1; k++) begin
         @(negedge clock);
         check("busy_ready_low", 32'(req_ready), 32'd0);
      end
      @(negedge clock);
      check("ready_again", 32'(req_ready), 32'd1);
      @(posedge clock);
      #1;
      a2 = cyc;
      check("issue_interval", 32'(a2 - a1), 32'(WA + 2));
      e.rdata = 32'hAA22CC44; e.err = 1'b0; e.acc = cyc;
      qa.push_back(e);
      req_valid = 1'b0;
      drain();

      // Zero-wait instance: store then load back-to-back with valid held
      @(negedge clock);
      b_we = 1'b1; b_addr = 32'h0; b_wdata = 32'hCAFEF00D; b_wstrb = 4'hF; b_valid = 1'b1;
      check("b_ready_idle", 32'(b_ready), 32'd1);
      @(posedge clock);
      #1;
      a1 = cyc;
      e.rdata = 32'd0; e.err = 1'b0; e.acc = cyc;
      qb.push_back(e);
      b_we = 1'b0; b_wdata = 32'd0;
      @(negedge clock);
      check("b_ready_resp", 32'(b_ready), 32'd0);
      @(negedge clock);
      check("b_ready_back", 32'(b_ready), 32'd1);
      @(posedge clock);
      #1;
      a2 = cyc;
      check("b_interval", 32'(a2 - a1), 32'd2);
      e.rdata = 32'hCAFEF00D; e.err = 1'b0; e.acc = cyc;
      qb.push_back(e);
      b_valid = 1'b0;
      drain();
      repeat (3) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
